// File: rtl/wallace_mult_pipe_if.sv
// Operand/product handshake bundle for wallace_mult_pipe.
// The master drives operands and out_ready; the slave is the multiplier.
interface wallace_mult_pipe_if #(
    parameter int WIDTH = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               signed_mode;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] P;

    modport master (
        output in_valid, A, B, signed_mode, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, signed_mode, out_ready,
        output in_ready, out_valid, P
    );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per operand set.
// CSA levels are spread over the first STAGES-1 registers; the last stage is the CPA into P.
module wallace_mult_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 5
) (
    input logic                clk,
    input logic                rst,
    wallace_mult_pipe_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int NR = WIDTH + 1;

    typedef logic [NR-1:0][PW-1:0] rows_t;

    function automatic int next_rows(input int n);
        return (n > 2) ? 2 * (n / 3) + n % 3 : n;
    endfunction

    function automatic int rows_after(input int levels);
        int n;
        n = NR;
        for (int i = 0; i < levels; i++) n = next_rows(n);
        return n;
    endfunction

    function automatic int count_levels();
        int n;
        int l;
        n = NR;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (n > 2) begin
                n = next_rows(n);
                l++;
            end
        end
        return l;
    endfunction

    localparam int LEVELS = count_levels();

    function automatic int level_mark(input int s);
        return (s * LEVELS + STAGES - 2) / (STAGES - 1);
    endfunction

    // Modified Baugh-Wooley: in signed mode the cross terms with one sign bit are
    // inverted and the extra row adds 2^WIDTH + 2^(2*WIDTH-1).
    function automatic rows_t gen_pp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic s);
        rows_t          r;
        logic [PW-1:0]  row;
        logic           pbit;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pbit = a[j] & b[i];
                if (s && ((i == WIDTH - 1) != (j == WIDTH - 1))) pbit = ~pbit;
                row[i + j] = pbit;
            end
            r[i] = row;
        end
        if (s) begin
            r[WIDTH][WIDTH]  = 1'b1;
            r[WIDTH][PW - 1] = 1'b1;
        end
        return r;
    endfunction

    function automatic rows_t csa_level(input rows_t r, input int n);
        rows_t o;
        int    groups;
        o = '0;
        groups = n / 3;
        for (int k = 0; k < NR / 3; k++) begin
            if (k < groups) begin
                o[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
                o[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) |
                            (r[3*k+1] & r[3*k+2])) << 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (k < n % 3) o[2*groups + k] = r[3*groups + k];
        end
        return o;
    endfunction

    rows_t                               pp;
    rows_t                               red;
    int                                  red_cnt;
    logic [STAGES-2:0][NR-1:0][PW-1:0]   stage_d;
    logic [STAGES-2:0][NR-1:0][PW-1:0]   stage_q;
    logic [STAGES-1:0]                   valid;
    logic [PW-1:0]                       p_q;
    logic [PW-1:0]                       cpa;
    logic                                adv;
    logic                                unused_hi_rows;

    assign adv           = !valid[STAGES-1] || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = valid[STAGES-1];
    assign bus.P         = p_q;

    assign pp  = gen_pp(bus.A, bus.B, bus.signed_mode);
    assign cpa = stage_q[STAGES-2][0] + stage_q[STAGES-2][1];

    // Rows above index 1 are always zero once the tree has fully reduced.
    assign unused_hi_rows = ^stage_q[STAGES-2][NR-1:2];

    // Each reduction stage applies its share of CSA levels to the previous stage's rows.
    always_comb begin
        stage_d = '0;
        red     = '0;
        red_cnt = 0;
        for (int s = 0; s < STAGES - 1; s++) begin
            if (s == 0) red = pp;
            else        red = stage_q[(s == 0) ? 0 : s - 1];
            red_cnt = rows_after(level_mark(s));
            for (int l = level_mark(s); l < level_mark(s + 1); l++) begin
                red     = csa_level(red, red_cnt);
                red_cnt = next_rows(red_cnt);
            end
            stage_d[s] = red;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) stage_q <= stage_d;
    end

    // P only loads on a valid product so it holds its last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            p_q   <= '0;
        end else if (adv) begin
            valid <= {valid[STAGES-2:0], bus.in_valid};
            if (valid[STAGES-2]) p_q <= cpa;
        end
    end
endmodule

// File: doc/wallace_mult_pipe.md
WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 Parameter STAGES, default 5, pipeline depth in register stages; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  A, B, signed_mode carry a valid operand set this cycle.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 A  input  WIDTH  multiplicand.
REQ-008 B  input  WIDTH  multiplier.
REQ-009 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 out_valid  output  1  P holds a valid product.
REQ-011 out_ready  input  1  consumer takes P this cycle.
REQ-012 P  output  2*WIDTH  full-width product.

Function
REQ-013 Block SHALL be a Wallace-tree multiplier: partial-product generation, CSA reduction and final carry-propagate add split across STAGES register stages.
REQ-014 Input transfer occurs on a rising edge with in_valid=1 and in_ready=1; output transfer on a rising edge with out_valid=1 and out_ready=1.
REQ-015 Global advance signal adv = (!out_valid) || out_ready; in_ready SHALL equal adv combinationally; all stages shift together only when adv=1.
REQ-016 When adv=0 every stage register, per-stage valid bit and P SHALL hold unchanged.
REQ-017 Each stage carries a valid bit; an accepted operand set SHALL appear on P with out_valid=1 exactly STAGES cycles after acceptance when adv stayed 1 throughout.
REQ-018 Bubbles (in_valid=0 while in_ready=1) SHALL propagate as invalid stages; out_valid=0 for them; no product generated.
REQ-019 Throughput: one product per cycle while out_ready=1 continuously.
REQ-020 Results SHALL leave in acceptance order; no loss or duplication under any out_ready pattern.
REQ-021 signed_mode=0: P = A*B, operands zero-extended, exact in 2*WIDTH bits.
REQ-022 signed_mode=1: P = A*B as two's complement (Baugh-Wooley correction), exact in 2*WIDTH bits, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-023 signed_mode SHALL be captured with its operands and travel with them; mode may change every cycle with no flush or extra latency.
REQ-024 P SHALL be registered (no combinational path from A/B to P); in_ready is the only combinational output (from out_valid, out_ready).

Reset
REQ-025 With rst=1 at a rising edge: all per-stage valid bits cleared, out_valid=0, P=0 after that edge.
REQ-026 rst SHALL override adv; operand sets in flight at reset are discarded and never emitted.
REQ-027 in_ready SHALL be 1 in the first cycle after rst deasserts (out_valid=0); inputs presented while rst=1 are not accepted.
REQ-028 Data-path registers other than P need no reset; their contents SHALL never be visible while out_valid=0 except P holding its last value.

Verification
REQ-029 WIDTH=16, STAGES=5, out_ready=1: unsigned A=0xFFFF, B=0xFFFF -> P=0xFFFE0001 with out_valid=1 exactly 5 cycles later; A=1234, B=0 -> P=0x00000000.
REQ-030 Signed, back-to-back cycles: 0xFFFF*0xFFFF -> 0x00000001; 0x8000*0x8000 -> 0x40000000; 0x8000*0x7FFF -> 0xC0008000; results on consecutive cycles, in order.
REQ-031 Alternating signed_mode each cycle with A=B=0xFFFF -> P alternates 0xFFFE0001 / 0x00000001 matching input order.
REQ-032 Stream 20 random operand sets, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during stall, P/out_valid held, all 20 products emerge in order against a reference model.
REQ-033 Load 3 operand sets, assert rst for 1 cycle at the 2nd cycle of flight -> out_valid=0 and P=0 after reset, none of the 3 products ever appear.
REQ-034 WIDTH=8, STAGES=2: signed 0xFF*0x80 -> P=0x0080 after 2 cycles; unsigned 0xFF*0x80 -> P=0x7F80.
